// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
// Shares one single-ported synchronous RAM between the fetch stage (IF) and
// the memory stage (MEM). At most one RAM access is issued per cycle. Read
// data comes back one cycle later and is tagged to the stage that owns it.
// MEM normally wins a conflict. IF wins once it has been denied MAX_WAIT
// consecutive cycles, so fetch cannot be starved. A saturating counter
// records every cycle in which both stages requested.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush   fetch request, address, return cancel
//   if_gnt/if_rvalid/stall_if fetch grant, fetch data valid, fetch stall
//   mem_req/mem_we/mem_addr/mem_wdata  load/store request
//   mem_gnt/mem_rvalid        load/store grant, load data valid
//   rdata                     read data to both stages (= ram_rdata)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM port
//   conflict_cnt              saturating count of IF+MEM conflict cycles
module imem_dmem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic              stall_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [SW-1:0] WAIT_LIM = SW'(MAX_WAIT);

    logic [SW-1:0]    starve_cnt_reg, starve_cnt_next;
    logic [CNT_W-1:0] conflict_cnt_reg, conflict_cnt_next;
    logic             if_pend_reg, if_pend_next;
    logic             mem_pend_reg, mem_pend_next;
    logic             if_win;
    logic             grant_if, grant_mem;

    // With MAX_WAIT=0 IF always wins a conflict; no compare against the
    // counter is needed in that configuration.
    generate
        if (MAX_WAIT == 0) begin : g_if_always
            assign if_win = 1'b1;
        end else begin : g_if_bounded
            assign if_win = (starve_cnt_reg >= WAIT_LIM);
        end
    endgenerate

    // Grant and RAM drive. Everything is gated by rst so the RAM sees no
    // access while reset is held, even with requests still asserted.
    always_comb begin
        grant_if  = rst & if_req & (~mem_req | if_win);
        grant_mem = rst & mem_req & ~grant_if;

        if_gnt    = grant_if;
        mem_gnt   = grant_mem;
        stall_if  = rst & if_req & ~grant_if;

        ram_en    = grant_if | grant_mem;
        ram_we    = grant_mem & mem_we;
        ram_addr  = '0;
        if (grant_mem) begin
            ram_addr = mem_addr;
        end else if (grant_if) begin
            ram_addr = if_addr;
        end
        ram_wdata = grant_mem ? mem_wdata : '0;

        // A flush in the return cycle kills the fetch data immediately.
        if_rvalid    = if_pend_reg & ~if_flush;
        mem_rvalid   = mem_pend_reg;
        rdata        = ram_rdata;
        conflict_cnt = conflict_cnt_reg;
    end

    // Next-state for starvation, return tags and conflict counter.
    always_comb begin
        starve_cnt_next = '0;
        if (if_req & ~grant_if) begin
            starve_cnt_next = (starve_cnt_reg >= WAIT_LIM) ? WAIT_LIM
                                                           : starve_cnt_reg + 1'b1;
        end

        if_pend_next  = grant_if & ~if_flush;
        mem_pend_next = grant_mem & ~mem_we;

        conflict_cnt_next = conflict_cnt_reg;
        if (if_req & mem_req & ~(&conflict_cnt_reg)) begin
            conflict_cnt_next = conflict_cnt_reg + 1'b1;
        end
    end

    // Async reset drops any return pending from the cycle before assertion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt_reg   <= '0;
            if_pend_reg      <= 1'b0;
            mem_pend_reg     <= 1'b0;
            conflict_cnt_reg <= '0;
        end else begin
            starve_cnt_reg   <= starve_cnt_next;
            if_pend_reg      <= if_pend_next;
            mem_pend_reg     <= mem_pend_next;
            conflict_cnt_reg <= conflict_cnt_next;
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Testbench for imem_dmem_port_arbiter. Two instances share the stimulus:
// dut (MAX_WAIT=3, CNT_W=16) and dut0 (MAX_WAIT=0, CNT_W=4). A behavioural
// model predicts every output on each falling edge; directed sequences add
// hand-computed literal checks.
module tb_imem_dmem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        mem_req = 1'b0, mem_we = 1'b0;
    logic [7:0]  mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] ram_rdata = '0;

    logic        a_if_gnt, a_if_rvalid, a_stall_if, a_mem_gnt, a_mem_rvalid;
    logic        a_ram_en, a_ram_we;
    logic [7:0]  a_ram_addr;
    logic [15:0] a_rdata, a_ram_wdata, a_conflict_cnt;
    logic        b_if_gnt, b_if_rvalid, b_stall_if, b_mem_gnt, b_mem_rvalid;
    logic        b_ram_en, b_ram_we;
    logic [7:0]  b_ram_addr;
    logic [15:0] b_rdata, b_ram_wdata;
    logic [3:0]  b_conflict_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imem_dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid), .stall_if(a_stall_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(a_mem_gnt), .mem_rvalid(a_mem_rvalid), .rdata(a_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(a_conflict_cnt)
    );

    imem_dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .stall_if(b_stall_if),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid), .rdata(b_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata), .conflict_cnt(b_conflict_cnt)
    );

    // Synchronous RAM attached to dut: preloaded with addr+0x100.
    logic [15:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i + 16'h100);
    end
    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_we) ram[a_ram_addr] = a_ram_wdata;
            else          ram_rdata <= ram[a_ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- behavioural model ----------------
    // denied[i]: consecutive cycles IF has been refused (unbounded count).
    int          denied [2] = '{0, 0};
    int          confl  [2] = '{0, 0};
    bit          ifp    [2] = '{0, 0};
    bit          memp   [2] = '{0, 0};
    logic [15:0] mmem   [256];
    logic [15:0] exp_rd = '0;
    int          mw     [2] = '{3, 0};
    int          cmax   [2] = '{65535, 15};

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = 16'(i + 16'h100);
    end

    function automatic bit m_if(int i);
        return rst && if_req && (!mem_req || denied[i] >= mw[i]);
    endfunction
    function automatic bit m_mem(int i);
        return rst && mem_req && !m_if(i);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                denied[i] = 0; confl[i] = 0; ifp[i] = 0; memp[i] = 0;
            end
        end else begin
            if (m_mem(0) && mem_we) mmem[mem_addr] = mem_wdata;
            else if (m_mem(0))      exp_rd = mmem[mem_addr];
            else if (m_if(0))       exp_rd = mmem[if_addr];
            for (int i = 0; i < 2; i++) begin
                bit gi, gm;
                gi = m_if(i);
                gm = m_mem(i);
                denied[i] = (if_req && !gi) ? denied[i] + 1 : 0;
                ifp[i]  = gi && !if_flush;
                memp[i] = gm && !mem_we;
                if (if_req && mem_req && confl[i] < cmax[i]) confl[i] = confl[i] + 1;
            end
        end
    end

    // Per-cycle compare of both instances against the model.
    always @(negedge clk) begin
        bit gi, gm, irv;
        gi = m_if(0); gm = m_mem(0); irv = ifp[0] && !if_flush;
        chk("a_if_gnt", 32'(a_if_gnt), 32'(gi));
        chk("a_mem_gnt", 32'(a_mem_gnt), 32'(gm));
        chk("a_stall_if", 32'(a_stall_if), 32'(rst && if_req && !gi));
        chk("a_ram_en", 32'(a_ram_en), 32'(gi || gm));
        chk("a_ram_we", 32'(a_ram_we), 32'(gm && mem_we));
        chk("a_ram_addr", 32'(a_ram_addr), gm ? 32'(mem_addr) : gi ? 32'(if_addr) : 32'd0);
        chk("a_ram_wdata", 32'(a_ram_wdata), gm ? 32'(mem_wdata) : 32'd0);
        chk("a_if_rvalid", 32'(a_if_rvalid), 32'(irv));
        chk("a_mem_rvalid", 32'(a_mem_rvalid), 32'(memp[0]));
        chk("a_conflict_cnt", 32'(a_conflict_cnt), 32'(confl[0]));
        if (irv || memp[0]) chk("a_rdata", 32'(a_rdata), 32'(exp_rd));
        gi = m_if(1); gm = m_mem(1);
        chk("b_if_gnt", 32'(b_if_gnt), 32'(gi));
        chk("b_mem_gnt", 32'(b_mem_gnt), 32'(gm));
        chk("b_stall_if", 32'(b_stall_if), 32'(rst && if_req && !gi));
        chk("b_ram_addr", 32'(b_ram_addr), gm ? 32'(mem_addr) : gi ? 32'(if_addr) : 32'd0);
        chk("b_if_rvalid", 32'(b_if_rvalid), 32'(ifp[1] && !if_flush));
        chk("b_mem_rvalid", 32'(b_mem_rvalid), 32'(memp[1]));
        chk("b_conflict_cnt", 32'(b_conflict_cnt), 32'(confl[1]));
        chk("b_rdata", 32'(b_rdata), 32'(ram_rdata));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req = 0; if_flush = 0; if_addr = '0;
        mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_if_gnt", 32'(a_if_gnt), 32'd0);
        chk("rst_conflict", 32'(a_conflict_cnt), 32'd0);
        cyc(); cyc();
        rst = 1;
        cyc();

        // 1: IF alone, addresses 0..3, data returns one cycle later
        for (int k = 0; k < 5; k++) begin
            if_req = (k < 4); if_addr = 8'(k);
            @(negedge clk);
            if (k < 4) begin
                chk("t1_if_gnt", 32'(a_if_gnt), 32'd1);
                chk("t1_stall", 32'(a_stall_if), 32'd0);
            end
            if (k >= 1) begin
                chk("t1_rvalid", 32'(a_if_rvalid), 32'd1);
                chk("t1_rdata", 32'(a_rdata), 32'h100 + 32'(k - 1));
            end
            cyc();
        end

        // 2: five conflict cycles with loads, MAX_WAIT=3
        for (int k = 1; k <= 5; k++) begin
            if_req = 1; if_addr = 8'h04; mem_req = 1; mem_we = 0; mem_addr = 8'h30;
            @(negedge clk);
            chk("t2_mem_gnt", 32'(a_mem_gnt), (k == 4) ? 32'd0 : 32'd1);
            chk("t2_if_gnt", 32'(a_if_gnt), (k == 4) ? 32'd1 : 32'd0);
            chk("t2_stall", 32'(a_stall_if), (k <= 3 || k == 5) ? 32'd1 : 32'd0);
            chk("t2_b_if_gnt", 32'(b_if_gnt), 32'd1);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("t2_conflict", 32'(a_conflict_cnt), 32'd5);
        chk("t2_rdata_if", 32'(a_rdata), 32'h0130);
        cyc();

        // 3: store
        mem_req = 1; mem_we = 1; mem_addr = 8'h10; mem_wdata = 16'h2010;
        @(negedge clk);
        chk("t3_ram_we", 32'(a_ram_we), 32'd1);
        chk("t3_ram_addr", 32'(a_ram_addr), 32'h10);
        chk("t3_ram_wdata", 32'(a_ram_wdata), 32'h2010);
        cyc();
        idle();
        @(negedge clk);
        chk("t3_no_rvalid", 32'(a_mem_rvalid), 32'd0);
        cyc();

        // 4: flush in the return cycle, then flush in the grant cycle
        if_req = 1; if_addr = 8'h20;
        @(negedge clk);
        chk("t4_gnt", 32'(a_if_gnt), 32'd1);
        cyc();
        idle(); if_flush = 1;
        @(negedge clk);
        chk("t4_flush_late", 32'(a_if_rvalid), 32'd0);
        cyc();
        if_req = 1; if_addr = 8'h20; if_flush = 1;
        @(negedge clk);
        chk("t4_gnt2", 32'(a_if_gnt), 32'd1);
        cyc();
        idle();
        @(negedge clk);
        chk("t4_flush_early", 32'(a_if_rvalid), 32'd0);
        cyc();

        // 5: async reset while a load is in flight
        mem_req = 1; mem_we = 0; mem_addr = 8'h10; if_req = 1;
        @(negedge clk);
        chk("t5_mem_gnt", 32'(a_mem_gnt), 32'd1);
        #1 rst = 0;
        #1;
        chk("t5_rst_mem_gnt", 32'(a_mem_gnt), 32'd0);
        chk("t5_rst_if_gnt", 32'(a_if_gnt), 32'd0);
        chk("t5_rst_ram_en", 32'(a_ram_en), 32'd0);
        chk("t5_rst_stall", 32'(a_stall_if), 32'd0);
        cyc();
        chk("t5_rvalid_dropped", 32'(a_mem_rvalid), 32'd0);
        idle();
        @(negedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("t5_cnt_clear", 32'(a_conflict_cnt), 32'd0);
        chk("t5_no_replay", 32'(a_mem_rvalid), 32'd0);
        cyc();

        // 6: 20 conflict cycles; 4-bit counter saturates, MAX_WAIT=0 IF wins
        for (int k = 0; k < 20; k++) begin
            if_req = 1; if_addr = 8'(k); mem_req = 1; mem_we = 0; mem_addr = 8'h40;
            @(negedge clk);
            chk("t6_b_if_gnt", 32'(b_if_gnt), 32'd1);
            chk("t6_b_mem_gnt", 32'(b_mem_gnt), 32'd0);
            cyc();
        end
        idle();
        @(negedge clk);
        chk("t6_b_sat", 32'(b_conflict_cnt), 32'd15);
        chk("t6_a_cnt", 32'(a_conflict_cnt), 32'd20);
        cyc(); cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
